// File: rtl/eth_frame_tx.sv
// Ethernet frame generator: on an accepted start it emits preamble, SFD, MAC header,
// payload and CRC32 FCS as a GMII-style byte stream, then holds busy through the IFG.
module eth_frame_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h000A35010203,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned PAYLOAD_LEN = 46,
  parameter int unsigned IFG_LEN     = 12
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        start_sending,
  input  logic [7:0]  txid,
  input  logic [7:0]  aux,
  input  logic [15:0] segment_num,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_done
);

  localparam int unsigned CNT_W    = 11;
  localparam logic [111:0] HDR     = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_IFG
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_crc;
  logic [7:0]       r_txid;
  logic [7:0]       r_aux;
  logic [15:0]      r_seg;

  state_t           w_nstate;
  logic [CNT_W-1:0] w_ncnt;
  logic             w_start;
  logic [7:0]       w_byte;

  // One byte of the reflected IEEE 802.3 CRC32, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Next state and byte index: the registered outputs always describe (w_nstate, w_ncnt).
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + CNT_W'(1);
    w_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ncnt = '0;
        if (start_sending) begin
          w_nstate = S_PRE;
          w_start  = 1'b1;
        end
      end
      S_PRE: if (r_cnt == CNT_W'(7)) begin
        w_nstate = S_HDR;
        w_ncnt   = '0;
      end
      S_HDR: if (r_cnt == CNT_W'(13)) begin
        w_nstate = S_PAY;
        w_ncnt   = '0;
      end
      S_PAY: if (r_cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
        w_nstate = S_FCS;
        w_ncnt   = '0;
      end
      S_FCS: if (r_cnt == CNT_W'(3)) begin
        w_nstate = S_IFG;
        w_ncnt   = '0;
      end
      S_IFG: if (r_cnt == CNT_W'(IFG_LEN - 1)) begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  // Byte to put on the wire for the next cycle.
  always_comb begin
    w_byte = 8'h00;
    case (w_nstate)
      S_PRE: w_byte = (w_ncnt == CNT_W'(7)) ? 8'hD5 : 8'h55;
      S_HDR: w_byte = 8'(HDR >> (7'd104 - {w_ncnt[3:0], 3'b000}));
      S_PAY: begin
        case (w_ncnt)
          CNT_W'(0): w_byte = r_txid;
          CNT_W'(1): w_byte = r_aux;
          CNT_W'(2): w_byte = r_seg[15:8];
          CNT_W'(3): w_byte = r_seg[7:0];
          default:   w_byte = w_ncnt[7:0];
        endcase
      end
      S_FCS: w_byte = 8'(~r_crc >> {w_ncnt[1:0], 3'b000});
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_crc   <= CRC_INIT;
      r_txid  <= '0;
      r_aux   <= '0;
      r_seg   <= '0;
      busy    <= 1'b0;
      tx_en   <= 1'b0;
      tx_done <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      busy    <= (w_nstate != S_IDLE);
      tx_en   <= (w_nstate inside {S_PRE, S_HDR, S_PAY, S_FCS});
      tx_done <= (w_nstate == S_FCS) && (w_ncnt == CNT_W'(3));
      tx_data <= w_byte;
      if (w_start) begin
        r_txid <= txid;
        r_aux  <= aux;
        r_seg  <= segment_num;
      end
      // CRC restarts on the SFD and accumulates header and payload bytes only.
      if (w_nstate == S_PRE && w_ncnt == CNT_W'(7)) begin
        r_crc <= CRC_INIT;
      end else if (w_nstate == S_HDR || w_nstate == S_PAY) begin
        r_crc <= crc_step(r_crc, w_byte);
      end
    end
  end

endmodule
